spi_slave_mem_param: RTL and testbench

Parametrised SPI slave with an internal register-file memory. It is the next generation of the fixed 8-bit, 32-entry SPI slave memory.
- Adds configurable address and data width.
- Adds burst read, configurable burst wrap, invalid-command signalling and clean CS-abort handling.
- All SPI inputs are oversampled in the system clock domain; it sits behind an external SPI master and the bench drives it directly.

---
 rtl/spi_slave_mem_param_pkg.sv | 33 +++
 rtl/spi_slave_mem_param_sync_edge.sv | 36 +++
 rtl/spi_slave_mem_param.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_slave_mem_param.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_mem_param_pkg.sv
// Shared definitions for the parametrised SPI slave memory.
//   CMD_W          : opcode width in bits
//   OP_*           : valid opcodes (single/burst write, single/burst read)
//   state_t        : frame FSM states
//   op_valid()     : opcode is one of the four defined commands
//   op_is_read()   : opcode starts a read data phase
package spi_mem_pkg;

  localparam int unsigned CMD_W = 3;

  localparam logic [CMD_W-1:0] OP_WR  = 3'b001;
  localparam logic [CMD_W-1:0] OP_RD  = 3'b010;
  localparam logic [CMD_W-1:0] OP_BWR = 3'b011;
  localparam logic [CMD_W-1:0] OP_BRD = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  function automatic logic op_valid(input logic [CMD_W-1:0] op);
    return (op == OP_WR) || (op == OP_RD) || (op == OP_BWR) || (op == OP_BRD);
  endfunction

  function automatic logic op_is_read(input logic [CMD_W-1:0] op);
    return (op == OP_RD) || (op == OP_BRD);
  endfunction

endpackage

// File: rtl/spi_slave_mem_param_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised value.
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronised level (STAGES clk of latency)
//   rise, fall : one-clk strobes on q transitions
// RST_VAL sets the level the chain (and edge history) holds in reset.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_mem_param.sv
// SPI mode-0 slave in front of a 2**ADDR_W x DATA_W register file.
// Frame: 3-bit opcode, ADDR_W-bit address, then DATA_W-bit words, MSB first.
//   clk, rst_n          : system clock (>= 6x sclk), async active-low reset
//   cs, sclk, mosi      : SPI inputs, asynchronous, oversampled on clk
//   miso, miso_oe       : serial read data and its drive enable
//   busy                : frame in progress (cs low after a seen falling edge)
//   cmd_err             : one-clk pulse on an invalid opcode
//   frame_abort         : one-clk pulse when cs rises mid-word
//   burst_ovf           : one-clk pulse when a non-wrapping burst runs past the top
module spi_slave_mem_param
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WRAP        = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic cmd_err,
  output logic frame_abort,
  output logic burst_ovf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned AD_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned SH_W  = (AD_W > CMD_W) ? AD_W : CMD_W;
  localparam int unsigned CNT_W = $clog2(SH_W);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);

  // cs resets to the low level so a cs held low across reset release shows
  // no falling edge; a frame needs cs to be seen high first.
  logic cs_s_unused, cs_rise, cs_fall;
  logic sclk_s_unused, sclk_rise, sclk_fall_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs),
    .q(cs_s_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .q(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t              state, state_nx;
  logic [SH_W-2:0]     sh_q;
  logic [SH_W-1:0]     sh_nx;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CMD_W-1:0]    op_q;
  logic [ADDR_W-1:0]   addr_q, addr_inc, addr_in;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   tx_q, wr_data;
  logic                wr_pend, past_end, oe_q;

  logic cmd_ok, cmd_bad, addr_done, wr_done, rd_done, abort_nx, ovf_nx;

  assign sh_nx    = {sh_q, mosi_s};
  assign addr_in  = sh_nx[ADDR_W-1:0];
  assign addr_inc = addr_q + ADDR_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // past_end is set once a non-wrapping burst has used the top word; the
  // overflow is flagged on the next bit, so a burst ending exactly at the top
  // of memory is a clean transfer.
  always_comb begin
    state_nx  = state;
    cmd_ok    = 1'b0;
    cmd_bad   = 1'b0;
    addr_done = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    abort_nx  = 1'b0;
    ovf_nx    = 1'b0;
    if (cs_rise) begin
      state_nx = ST_IDLE;
      case (state)
        ST_CMD, ST_ADDR:   abort_nx = 1'b1;
        ST_WDATA, ST_RDATA: abort_nx = (bit_cnt != '0);
        default:           abort_nx = 1'b0;
      endcase
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nx = ST_CMD;
        ST_CMD: begin
          if (sclk_rise && bit_cnt == CMD_LAST) begin
            if (op_valid(sh_nx[CMD_W-1:0])) begin
              cmd_ok   = 1'b1;
              state_nx = ST_ADDR;
            end else begin
              cmd_bad  = 1'b1;
              state_nx = ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise && bit_cnt == ADDR_LAST) begin
            addr_done = 1'b1;
            state_nx  = op_is_read(op_q) ? ST_RDATA : ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
            if (past_end) begin
              ovf_nx   = 1'b1;
              state_nx = ST_IGNORE;
            end else if (bit_cnt == DATA_LAST) begin
              wr_done = 1'b1;
              if (op_q == OP_WR) state_nx = ST_IGNORE;
            end
          end
        end
        ST_RDATA: begin
          if (sclk_rise) begin
            if (past_end) begin
              ovf_nx   = 1'b1;
              state_nx = ST_IGNORE;
            end else if (bit_cnt == DATA_LAST) begin
              rd_done = 1'b1;
              if (op_q == OP_RD) state_nx = ST_IGNORE;
            end
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      bit_cnt     <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      wr_data     <= '0;
      wr_pend     <= 1'b0;
      past_end    <= 1'b0;
      oe_q        <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
      frame_abort <= 1'b0;
      burst_ovf   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cmd_err     <= cmd_bad;
      frame_abort <= abort_nx;
      burst_ovf   <= ovf_nx;
      busy        <= (state_nx != ST_IDLE);

      if (sclk_rise) sh_q <= sh_nx[SH_W-2:0];

      if (cs_fall || cs_rise || cmd_ok || cmd_bad || addr_done || wr_done || rd_done)
        bit_cnt <= '0;
      else if (sclk_rise)
        bit_cnt <= bit_cnt + CNT_W'(1);

      if (cmd_ok)  op_q     <= sh_nx[CMD_W-1:0];
      if (cs_fall) past_end <= 1'b0;

      // Completed write words land one clk after their last bit.
      wr_pend <= wr_done;
      if (wr_done) wr_data <= sh_nx[DATA_W-1:0];
      if (wr_pend) begin
        mem[addr_q] <= wr_data;
        if (op_q == OP_BWR) begin
          addr_q <= addr_inc;
          if (addr_q == ADDR_TOP && WRAP == 0) past_end <= 1'b1;
        end
      end

      if (addr_done) begin
        addr_q <= addr_in;
        if (op_is_read(op_q)) begin
          tx_q <= mem[addr_in];
          oe_q <= 1'b1;
        end
      end else if (rd_done && op_q == OP_BRD) begin
        if (addr_q == ADDR_TOP && WRAP == 0) begin
          tx_q     <= '0;
          past_end <= 1'b1;
        end else begin
          tx_q   <= mem[addr_inc];
          addr_q <= addr_inc;
        end
      end else if (sclk_rise && state == ST_RDATA) begin
        tx_q <= tx_q << 1;
      end

      if (state_nx == ST_IDLE) begin
        oe_q <= 1'b0;
        tx_q <= '0;
      end
    end
  end

  assign miso    = tx_q[DATA_W-1];
  assign miso_oe = oe_q;

endmodule

// File: tb/tb_spi_slave_mem_param.sv
module tb_spi_slave_mem_param;

  localparam int CLK  = 10;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n, cs, sclk, mosi;
  logic miso, miso_oe, busy, cmd_err, frame_abort, burst_ovf;
  logic miso_w, miso_oe_w, busy_w, cmd_err_w, frame_abort_w, burst_ovf_w;

  always #(CLK/2) clk = ~clk;

  spi_slave_mem_param #(.ADDR_W(5), .DATA_W(8), .SYNC_STAGES(2), .WRAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .busy(busy), .cmd_err(cmd_err),
    .frame_abort(frame_abort), .burst_ovf(burst_ovf)
  );

  spi_slave_mem_param #(.ADDR_W(5), .DATA_W(8), .SYNC_STAGES(2), .WRAP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .mosi(mosi),
    .miso(miso_w), .miso_oe(miso_oe_w), .busy(busy_w), .cmd_err(cmd_err_w),
    .frame_abort(frame_abort_w), .burst_ovf(burst_ovf_w)
  );

  int checks = 0;
  int errors = 0;

  int n_cerr = 0, n_cerr_w = 0, n_ab = 0, n_ab_w = 0, n_ovf = 0, n_ovf_w = 0, n_stray = 0;
  logic rd_phase = 1'b0;

  logic       strm   [0:199];
  logic       strm_w [0:199];
  int         p = 0;
  logic [7:0] wbuf [0:15];

  always @(negedge clk) begin
    if (cmd_err)       n_cerr++;
    if (cmd_err_w)     n_cerr_w++;
    if (frame_abort)   n_ab++;
    if (frame_abort_w) n_ab_w++;
    if (burst_ovf)     n_ovf++;
    if (burst_ovf_w)   n_ovf_w++;
    if ((miso_oe || miso_oe_w) && !rd_phase) n_stray++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One SPI bit: drive mosi, raise sclk, sample miso just before sclk falls.
  task automatic bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      #(HALF);
      sclk = 1'b1;
      #(HALF);
      if (p < 200) begin
        strm[p]   = miso;
        strm_w[p] = miso_w;
      end
      p++;
      sclk = 1'b0;
    end
  endtask

  // Read word i starts at the sample taken after the last address bit (index 7).
  function automatic logic [7:0] word(input int i, input bit w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[7-k] = w ? strm_w[7+8*i+k] : strm[7+8*i+k];
    return r;
  endfunction

  task automatic frame(input logic [2:0] op, input logic [4:0] a, input int nw, input int extra);
    logic rd;
    rd = (op == 3'b010) || (op == 3'b100);
    p  = 0;
    cs = 1'b0;
    #(2*HALF);
    chk("busy_on", {busy, busy_w}, 2'b11);
    bits({5'b0, op}, 3);
    bits({3'b0, a} >> 1, 4);
    rd_phase = rd;
    bits({3'b0, a}, 1);
    chk("oe_data", {miso_oe, miso_oe_w}, {rd, rd});
    for (int w = 0; w < nw; w++) bits(wbuf[w], 8);
    for (int e = 0; e < extra; e++) bits(8'hFF, 1);
    #(HALF);
    cs = 1'b1;
    #(6*CLK);
    chk("busy_off", {busy, busy_w}, 2'b00);
    chk("oe_off", {miso_oe, miso_oe_w}, 2'b00);
    rd_phase = 1'b0;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [7:0] d);
    wbuf[0] = d;
    frame(3'b001, a, 1, 0);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] e, input logic [7:0] ew);
    frame(3'b010, a, 1, 0);
    chk(tag, word(0, 0), e);
    chk({tag, "_w"}, word(0, 1), ew);
  endtask

  int o0, ow0, a0, aw0, c0, cw0, s0;
  logic [7:0] tbl [0:15] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h12, 8'h34,
                             8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hAB, 8'hCD};

  initial begin
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", {miso, miso_oe, busy, cmd_err, frame_abort, burst_ovf}, 6'd0);
    chk("reset_out_w", {miso_w, miso_oe_w, busy_w, cmd_err_w, frame_abort_w, burst_ovf_w}, 6'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single write then single read; second word after a single read is 0
    wr1(5'h01, 8'h01);
    wbuf[0] = 8'h00; wbuf[1] = 8'h00;
    frame(3'b010, 5'h01, 2, 0);
    chk("rd1", word(0, 0), 8'h01);
    chk("rd1_w", word(0, 1), 8'h01);
    chk("rd1_tail", word(1, 0), 8'h00);
    chk("rd1_tail_w", word(1, 1), 8'h00);

    // 16-word burst write / burst read ending exactly at the top
    for (int i = 0; i < 16; i++) wbuf[i] = tbl[i];
    o0 = n_ovf; ow0 = n_ovf_w; a0 = n_ab;
    frame(3'b011, 5'h10, 16, 0);
    frame(3'b100, 5'h10, 16, 0);
    for (int i = 0; i < 16; i++) begin
      chk("burst_rd", word(i, 0), tbl[i]);
      chk("burst_rd_w", word(i, 1), tbl[i]);
    end
    chk("burst_no_ovf", n_ovf - o0, 0);
    chk("burst_no_ovf_w", n_ovf_w - ow0, 0);
    chk("burst_no_abort", n_ab - a0, 0);

    // burst write across the top of memory
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    o0 = n_ovf; ow0 = n_ovf_w; a0 = n_ab; aw0 = n_ab_w;
    frame(3'b011, 5'h1E, 3, 0);
    chk("top_ovf", n_ovf - o0, 1);
    chk("top_ovf_w", n_ovf_w - ow0, 0);
    chk("top_abort", n_ab - a0, 0);
    chk("top_abort_w", n_ab_w - aw0, 0);
    rd("top_1e", 5'h1E, 8'h11, 8'h11);
    rd("top_1f", 5'h1F, 8'h22, 8'h22);
    rd("top_00", 5'h00, 8'h00, 8'h33);

    // invalid opcode 111 with 13 trailing bits
    c0 = n_cerr; cw0 = n_cerr_w; a0 = n_ab;
    wbuf[0] = 8'h11;
    frame(3'b111, 5'h01, 1, 0);
    chk("cmd_err", n_cerr - c0, 1);
    chk("cmd_err_w", n_cerr_w - cw0, 1);
    chk("cmd_err_abort", n_ab - a0, 0);
    rd("inv_01", 5'h01, 8'h01, 8'h01);
    rd("inv_10", 5'h10, 8'hA1, 8'hA1);
    rd("inv_00", 5'h00, 8'h00, 8'h33);

    // cs abort after 4 data bits, then a full write
    a0 = n_ab; aw0 = n_ab_w;
    frame(3'b001, 5'h05, 0, 4);
    chk("abort", n_ab - a0, 1);
    chk("abort_w", n_ab_w - aw0, 1);
    rd("abort_mem", 5'h05, 8'h00, 8'h00);
    wr1(5'h05, 8'h5A);
    rd("after_abort", 5'h05, 8'h5A, 8'h5A);

    // reset in the middle of the third word of a burst write
    p = 0;
    cs = 1'b0;
    #(2*HALF);
    bits(8'h03, 3);
    bits(8'h08, 5);
    bits(8'hAA, 8);
    bits(8'hBB, 8);
    bits(8'h05, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {miso, miso_oe, busy, cmd_err, frame_abort, burst_ovf}, 6'd0);
    chk("midrst_out_w", {miso_w, miso_oe_w, busy_w, cmd_err_w, frame_abort_w, burst_ovf_w}, 6'd0);
    #(2*CLK - 1);
    rst_n = 1'b1;
    a0 = n_ab; c0 = n_cerr;
    bits(8'h4A, 8);
    chk("cs_held_busy", {busy, busy_w}, 2'b00);
    chk("cs_held_oe", {miso_oe, miso_oe_w}, 2'b00);
    #(HALF);
    cs = 1'b1;
    #(6*CLK);
    chk("cs_held_abort", n_ab - a0, 0);
    chk("cs_held_cerr", n_cerr - c0, 0);
    rd("rst_08", 5'h08, 8'h00, 8'h00);
    rd("rst_09", 5'h09, 8'h00, 8'h00);
    rd("rst_01", 5'h01, 8'h00, 8'h00);
    rd("rst_05", 5'h05, 8'h00, 8'h00);
    rd("rst_1f", 5'h1F, 8'h00, 8'h00);
    rd("rst_00", 5'h00, 8'h00, 8'h00);
    wr1(5'h02, 8'h3C);
    rd("post_rst", 5'h02, 8'h3C, 8'h3C);

    chk("oe_stray", n_stray, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
